// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - rv32i decode-side instruction queue with head field split
// Optional feature macro: INSTR_ILLEGAL_CHECK_EN (adds illegal_instr output)
package rv32i_pkg;
   localparam int DPW = 32;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_FENCE  = 7'b0001111,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111,
      OPC_SYSTEM = 7'b1110011
   } instr_type_t;

   typedef logic [2:0] func_code_t;
endpackage

module instr_decode_queue
   import rv32i_pkg::*;
#(
   parameter int ADW   = 5,
   parameter int DEPTH = 4,
   parameter int PCW   = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DPW-1:0]               in_instr,
   input  logic [PCW-1:0]               in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output instr_type_t                  instr_type,
   output func_code_t                   func_code,
   output logic                         funct7b5,
   output logic [ADW-1:0]               addr_1,
   output logic [ADW-1:0]               addr_2,
   output logic [4:0]                   RdD,
   output logic [DPW-8:0]               instr_ext,
   output logic [PCW-1:0]               out_pc,
`ifdef INSTR_ILLEGAL_CHECK_EN
   output logic                         illegal_instr,
`endif
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DPW-1:0] mem_instr [DEPTH];
   logic [PCW-1:0] mem_pc    [DEPTH];

   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q,  count_d;
   logic           push, pop;
   logic [DPW-1:0] head_instr;
   logic [PCW-1:0] head_pc;

   always_comb begin
      in_ready  = (count_q != CW'(DEPTH));
      out_valid = (count_q != '0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately unreset; out_valid gating hides stale contents.
   always_ff @(posedge clk) begin
      if (push && !flush && !reset) begin
         mem_instr[wr_ptr_q] <= in_instr;
         mem_pc[wr_ptr_q]    <= in_pc;
      end
   end

   always_comb begin
      head_instr = out_valid ? mem_instr[rd_ptr_q] : '0;
      head_pc    = out_valid ? mem_pc[rd_ptr_q]    : '0;
      instr_type = instr_type_t'(head_instr[6:0]);
      func_code  = head_instr[14:12];
      funct7b5   = head_instr[30];
      addr_1     = ADW'(head_instr[19:15]);
      addr_2     = ADW'(head_instr[24:20]);
      RdD        = head_instr[11:7];
      instr_ext  = head_instr[DPW-1:7];
      out_pc     = head_pc;
      count      = count_q;
   end

`ifdef INSTR_ILLEGAL_CHECK_EN
   logic opcode_known;

   always_comb begin
      opcode_known = 1'b0;
      case (head_instr[6:0])
         OPC_LOAD, OPC_FENCE, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
         OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: opcode_known = 1'b1;
         default: opcode_known = 1'b0;
      endcase
      illegal_instr = out_valid & ((head_instr[1:0] != 2'b11) | !opcode_known);
   end
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// tb/tb_instr_decode_queue.sv - directed table-driven bench for instr_decode_queue
// Optional feature macro: INSTR_ILLEGAL_CHECK_EN
module tb_instr_decode_queue;
   import rv32i_pkg::*;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]       in_instr, in_pc, out_pc;
   instr_type_t       instr_type;
   func_code_t        func_code;
   logic              funct7b5;
   logic [4:0]        addr_1, addr_2, RdD;
   logic [24:0]       instr_ext;
   logic [2:0]        count;
`ifdef INSTR_ILLEGAL_CHECK_EN
   logic              illegal_instr;
`endif

   int checks   = 0;
   int failures = 0;

   instr_decode_queue #(.ADW(5), .DEPTH(4), .PCW(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .instr_type(instr_type), .func_code(func_code), .funct7b5(funct7b5),
      .addr_1(addr_1), .addr_2(addr_2), .RdD(RdD), .instr_ext(instr_ext),
      .out_pc(out_pc),
`ifdef INSTR_ILLEGAL_CHECK_EN
      .illegal_instr(illegal_instr),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        ordy;
      logic        e_ov;
      logic        e_ir;
      logic [2:0]  e_cnt;
      logic [31:0] e_word;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] head_word();
      logic [6:0] op;
      op = instr_type;
      return {instr_ext, op};
   endfunction

   task automatic drive(input logic fl, input logic iv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy);
      @(negedge clk);
      flush = fl; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; flush = 0; in_valid = 0; out_ready = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 0; in_valid = 0; in_instr = '0; in_pc = '0; out_ready = 0;

      // fl iv instr pc ordy | ov ir cnt word pc  (expected during the cycle, before its edge)
      vecs[0]  = '{0, 1, 32'h00100113, 32'h04, 0, 1, 1, 3'd1, 32'h00500093, 32'h00};
      vecs[1]  = '{0, 1, 32'h00200193, 32'h08, 0, 1, 1, 3'd2, 32'h00500093, 32'h00};
      vecs[2]  = '{0, 1, 32'h00300213, 32'h0C, 0, 1, 1, 3'd3, 32'h00500093, 32'h00};
      vecs[3]  = '{0, 1, 32'h00400293, 32'h10, 0, 1, 0, 3'd4, 32'h00500093, 32'h00};
      vecs[4]  = '{0, 1, 32'h00400293, 32'h10, 1, 1, 0, 3'd4, 32'h00500093, 32'h00};
      vecs[5]  = '{0, 0, 32'h0,        32'h00, 1, 1, 1, 3'd3, 32'h00100113, 32'h04};
      vecs[6]  = '{0, 0, 32'h0,        32'h00, 1, 1, 1, 3'd2, 32'h00200193, 32'h08};
      vecs[7]  = '{0, 0, 32'h0,        32'h00, 1, 1, 1, 3'd1, 32'h00300213, 32'h0C};
      vecs[8]  = '{0, 0, 32'h0,        32'h00, 1, 0, 1, 3'd0, 32'h00000000, 32'h00};
      vecs[9]  = '{0, 1, 32'h00600393, 32'h20, 0, 0, 1, 3'd0, 32'h00000000, 32'h00};
      vecs[10] = '{0, 1, 32'h00700413, 32'h24, 0, 1, 1, 3'd1, 32'h00600393, 32'h20};
      vecs[11] = '{0, 1, 32'h00800493, 32'h28, 1, 1, 1, 3'd2, 32'h00600393, 32'h20};
      vecs[12] = '{0, 0, 32'h0,        32'h00, 0, 1, 1, 3'd2, 32'h00700413, 32'h24};
      vecs[13] = '{0, 1, 32'h00900513, 32'h2C, 0, 1, 1, 3'd2, 32'h00700413, 32'h24};
      vecs[14] = '{1, 1, 32'h00A00593, 32'h30, 0, 1, 1, 3'd3, 32'h00700413, 32'h24};
      vecs[15] = '{0, 0, 32'h0,        32'h00, 0, 0, 1, 3'd0, 32'h00000000, 32'h00};
      vecs[16] = '{0, 1, 32'h00B00613, 32'h34, 0, 0, 1, 3'd0, 32'h00000000, 32'h00};
      vecs[17] = '{0, 0, 32'h0,        32'h00, 0, 1, 1, 3'd1, 32'h00B00613, 32'h34};

      do_reset();
      #1;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_word", head_word(), 32'h0);
      chk("reset_pc", out_pc, 32'h0);

      // addi x1,x0,5 appears one cycle after the push
      drive(0, 1, 32'h00500093, 32'h0, 0);
      chk("t1_pre_out_valid", 32'(out_valid), 32'd0);
      drive(0, 0, 32'h0, 32'h0, 0);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_addr_1", 32'(addr_1), 32'd0);
      chk("t1_RdD", 32'(RdD), 32'd1);
      chk("t1_func_code", 32'(func_code), 32'd0);
      chk("t1_out_pc", out_pc, 32'h0);
      chk("t1_count", 32'(count), 32'd1);

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].fl, vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].ordy);
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d_word", i), head_word(), vecs[i].e_word);
         chk($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
      end

      // sub x10,x10,x11 replaces the head via simultaneous push+pop
      drive(0, 1, 32'h40B50533, 32'h40, 1);
      drive(0, 1, 32'h00500093, 32'h44, 0);
      chk("t5_funct7b5", 32'(funct7b5), 32'd1);
      chk("t5_addr_1", 32'(addr_1), 32'd10);
      chk("t5_addr_2", 32'(addr_2), 32'd11);
      chk("t5_RdD", 32'(RdD), 32'd10);
      chk("t5_func_code", 32'(func_code), 32'd0);
      chk("t5_type", 32'(head_word() & 32'h7F), 32'h33);
      chk("t5_pc", out_pc, 32'h40);
      chk("t5_count", 32'(count), 32'd1);
      @(negedge clk);
      reset = 1'b1; in_valid = 0;
      #1;
      chk("t5_pre_reset_count", 32'(count), 32'd2);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t5_rst_count", 32'(count), 32'd0);
      chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
      chk("t5_rst_word", head_word(), 32'h0);
      chk("t5_rst_pc", out_pc, 32'h0);
      chk("t5_rst_fields", 32'({funct7b5, addr_1, addr_2, RdD, func_code}), 32'd0);

`ifdef INSTR_ILLEGAL_CHECK_EN
      chk("t6_rst_illegal", 32'(illegal_instr), 32'd0);
      drive(0, 1, 32'h00000000, 32'h80, 0);
      drive(0, 1, 32'h00000013, 32'h84, 0);
      chk("t6_illegal_zero", 32'(illegal_instr), 32'd1);
      drive(0, 0, 32'h0, 32'h0, 1);
      chk("t6_illegal_still", 32'(illegal_instr), 32'd1);
      drive(0, 0, 32'h0, 32'h0, 0);
      chk("t6_legal_nop", 32'(illegal_instr), 32'd0);
      chk("t6_count", 32'(count), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
